// File: rtl/dma_complete_sched_pkg.sv
// dma_complete_sched_pkg: shared state encoding and counter sizing for the completion scheduler
package dma_complete_sched_pkg;

    typedef enum logic {
        PASS = 1'b0,
        CMPL = 1'b1
    } sched_state_t;

    // One guard bit above the counter width catches a saturating add before clamping
    localparam int SAT_GUARD_BITS = 1;

endpackage

// File: rtl/dma_complete_sched_sat_updown_counter.sv
// sat_updown_counter: up-by-value / down-by-one counter that clamps at all-ones and flags the clamp
module sat_updown_counter
    import dma_complete_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam int SW = WIDTH + SAT_GUARD_BITS;

    logic          dec_ok;
    logic [SW-1:0] sum;

    // A decrement with nothing to take from is ignored rather than wrapping
    assign dec_ok   = dec && (count != '0 || inc != '0);
    assign sum      = SW'(count) + SW'(inc) - SW'(dec_ok);
    assign overflow = |sum[SW-1:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else          count <= overflow ? '1 : sum[WIDTH-1:0];
    end

endmodule

// File: rtl/dma_complete_sched.sv
// dma_complete_sched: turns PS doorbell completion counts into one-cycle dma_complete pulses
// slotted into gaps of the AW address stream, dropping completions that have no open packet.
module dma_complete_sched
    import dma_complete_sched_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int BASE_ADDR   = 0,
    parameter int PEND_WIDTH  = 4,
    parameter int OUT_WIDTH   = 3,
    parameter int HOLDOFF_MAX = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] s_addr_data,
    input  logic                  s_addr_valid,
    output logic                  s_addr_ready,
    output logic [ADDR_WIDTH-1:0] m_addr_data,
    output logic                  m_addr_valid,
    input  logic                  m_addr_ready,
    input  logic                  i_doorbell_valid,
    input  logic [PEND_WIDTH-1:0] i_doorbell_count,
    input  logic                  i_clear_flags,
    output logic                  o_dma_complete,
    output logic [PEND_WIDTH-1:0] o_pending_count,
    output logic [OUT_WIDTH-1:0]  o_open_count,
    output logic                  o_spurious,
    output logic                  o_overflow
);

    localparam int HW = $clog2(HOLDOFF_MAX + 1);

    sched_state_t    state, state_next;
    logic [HW-1:0]   holdoff;
    logic            in_pass, beat, wrap, pend_nz, open_nz;
    logic            go, drop, pend_ovf, open_ovf;

    assign in_pass      = state == PASS;
    assign m_addr_data  = s_addr_data;
    // Gating with reset_n keeps the stream closed while reset is held
    assign m_addr_valid = reset_n && in_pass && s_addr_valid;
    assign s_addr_ready = reset_n && in_pass && m_addr_ready;
    assign beat         = m_addr_valid && m_addr_ready;
    assign wrap         = beat && s_addr_data == ADDR_WIDTH'(BASE_ADDR);
    assign pend_nz      = o_pending_count != '0;
    assign open_nz      = o_open_count != '0;

    assign go   = in_pass && pend_nz && (open_nz || wrap) &&
                  (!s_addr_valid || holdoff == HW'(HOLDOFF_MAX));
    assign drop = in_pass && pend_nz && !open_nz && !wrap;

    assign o_dma_complete = state == CMPL;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= PASS;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == CMPL) state_next = PASS;
        else if (go)       state_next = CMPL;
    end

    sat_updown_counter #(.WIDTH(PEND_WIDTH)) u_pending (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (i_doorbell_valid ? i_doorbell_count : '0),
        .dec      (go || drop),
        .count    (o_pending_count),
        .overflow (pend_ovf)
    );

    sat_updown_counter #(.WIDTH(OUT_WIDTH)) u_open (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (OUT_WIDTH'(wrap)),
        .dec      (o_dma_complete),
        .count    (o_open_count),
        .overflow (open_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       holdoff <= '0;
        else if (o_dma_complete || !pend_nz) holdoff <= '0;
        else if (beat && holdoff != HW'(HOLDOFF_MAX)) holdoff <= holdoff + 1'b1;
    end

    // A set event in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_spurious <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_spurious <= drop || (o_spurious && !i_clear_flags);
            o_overflow <= pend_ovf || open_ovf || (o_overflow && !i_clear_flags);
        end
    end

endmodule

// File: tb/tb_dma_complete_sched.sv
// tb_dma_complete_sched: table vectors, directed corner sequences and a randomized run
// checked against an integer reference model of the completion-scheduling rules.
module tb_dma_complete_sched;

    localparam int AW = 12, PW = 4, OW = 3, HM = 16;
    localparam int PMAX = (1 << PW) - 1, OMAX = (1 << OW) - 1;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic [AW-1:0] s_addr_data = '0, m_addr_data;
    logic          s_addr_valid = 1'b0, s_addr_ready, m_addr_valid, m_addr_ready = 1'b0;
    logic          i_doorbell_valid = 1'b0, i_clear_flags = 1'b0;
    logic [PW-1:0] i_doorbell_count = '0, o_pending_count;
    logic [OW-1:0] o_open_count;
    logic          o_dma_complete, o_spurious, o_overflow;

    dma_complete_sched #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .PEND_WIDTH(PW), .OUT_WIDTH(OW),
                         .HOLDOFF_MAX(HM)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_addr_data(s_addr_data), .s_addr_valid(s_addr_valid), .s_addr_ready(s_addr_ready),
        .m_addr_data(m_addr_data), .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready),
        .i_doorbell_valid(i_doorbell_valid), .i_doorbell_count(i_doorbell_count),
        .i_clear_flags(i_clear_flags), .o_dma_complete(o_dma_complete),
        .o_pending_count(o_pending_count), .o_open_count(o_open_count),
        .o_spurious(o_spurious), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int m_pend, m_open, m_hold;
    bit m_cmpl, m_spur, m_ovf;

    typedef struct {
        bit          sv;
        logic [11:0] a;
        bit          mr, db;
        logic [3:0]  cnt;
        bit          done;
        int          pend, open;
        bit          mv, spur, ovf;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_open = 0; m_hold = 0;
        m_cmpl = 0; m_spur = 0; m_ovf = 0;
    endtask

    task automatic compare_model();
        chk("m_addr_valid", int'(m_addr_valid), int'(!m_cmpl && s_addr_valid));
        chk("s_addr_ready", int'(s_addr_ready), int'(!m_cmpl && m_addr_ready));
        chk("m_addr_data", int'(m_addr_data), int'(s_addr_data));
        chk("dma_complete", int'(o_dma_complete), int'(m_cmpl));
        chk("pending", int'(o_pending_count), m_pend);
        chk("open", int'(o_open_count), m_open);
        chk("spurious", int'(o_spurious), int'(m_spur));
        chk("overflow", int'(o_overflow), int'(m_ovf));
    endtask

    // Advances the model one clock using the inputs currently driven
    task automatic model_clock();
        bit beat, wrap, go, drop, ov;
        int p, o;
        beat = !m_cmpl && s_addr_valid && m_addr_ready;
        wrap = beat && s_addr_data == 0;
        go   = !m_cmpl && m_pend > 0 && (m_open > 0 || wrap) && (!s_addr_valid || m_hold == HM);
        drop = !m_cmpl && m_pend > 0 && m_open == 0 && !wrap;
        p    = m_pend + (i_doorbell_valid ? int'(i_doorbell_count) : 0) - int'(go || drop);
        o    = m_open + int'(wrap) - int'(m_cmpl);
        ov   = p > PMAX || o > OMAX;
        m_hold = (m_cmpl || m_pend == 0) ? 0 : (beat && m_hold < HM) ? m_hold + 1 : m_hold;
        m_pend = p > PMAX ? PMAX : p;
        m_open = o > OMAX ? OMAX : o;
        m_spur = drop || (m_spur && !i_clear_flags);
        m_ovf  = ov || (m_ovf && !i_clear_flags);
        m_cmpl = go;
    endtask

    task automatic apply(input bit sv, input logic [11:0] a, input bit mr, input bit db,
                         input logic [3:0] cnt, input bit clr);
        s_addr_valid = sv; s_addr_data = a; m_addr_ready = mr;
        i_doorbell_valid = db; i_doorbell_count = cnt; i_clear_flags = clr;
        #1;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        int pulse_at, pulses;

        tbl[0]  = '{1, 12'h000, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 12'h004, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[2]  = '{1, 12'h008, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[3]  = '{1, 12'h00c, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[4]  = '{0, 12'h000, 1, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{0, 12'h000, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[6]  = '{0, 12'h000, 1, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 12'h000, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{1, 12'h000, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[10] = '{0, 12'h000, 1, 1, 2, 0, 0, 2, 0, 0, 0};
        tbl[11] = '{0, 12'h000, 1, 0, 0, 0, 2, 2, 0, 0, 0};
        tbl[12] = '{0, 12'h000, 1, 0, 0, 1, 1, 2, 0, 0, 0};
        tbl[13] = '{0, 12'h000, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[14] = '{0, 12'h000, 1, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[15] = '{0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        model_reset();
        do_reset();

        // Single packet followed by two back-to-back packets
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].sv, tbl[i].a, tbl[i].mr, tbl[i].db, tbl[i].cnt, 0);
            chk($sformatf("tbl%0d_done", i), int'(o_dma_complete), int'(tbl[i].done));
            chk($sformatf("tbl%0d_pend", i), int'(o_pending_count), tbl[i].pend);
            chk($sformatf("tbl%0d_open", i), int'(o_open_count), tbl[i].open);
            chk($sformatf("tbl%0d_mvalid", i), int'(m_addr_valid), int'(tbl[i].mv));
            chk($sformatf("tbl%0d_spur", i), int'(o_spurious), int'(tbl[i].spur));
            chk($sformatf("tbl%0d_ovf", i), int'(o_overflow), int'(tbl[i].ovf));
            compare_model();
            tick();
        end

        // Holdoff: continuous traffic forces the pulse once the holdoff saturates
        do_reset();
        apply(1, 12'h000, 1, 0, 0, 0); compare_model(); tick();
        apply(1, 12'h004, 1, 1, 1, 0); compare_model(); tick();
        pulse_at = -1; pulses = 0;
        for (int k = 0; k < 40; k++) begin
            apply(1, 12'h004, 1, 0, 0, 0);
            compare_model();
            chk("hold_no_lost_beat", int'(s_addr_ready), int'(m_addr_valid && m_addr_ready));
            if (o_dma_complete) begin
                pulses++;
                if (pulse_at < 0) pulse_at = k;
                chk("hold_pulse_mvalid", int'(m_addr_valid), 0);
                chk("hold_pulse_sready", int'(s_addr_ready), 0);
            end
            tick();
        end
        chk("hold_pulse_cycle", pulse_at, HM + 1);
        chk("hold_pulse_count", pulses, 1);
        chk("hold_open_after", int'(o_open_count), 0);

        // Spurious: completions with no open packet are dropped one per cycle
        do_reset();
        apply(0, 0, 1, 1, 3, 0); compare_model(); tick();
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 1, 0, 0, 0);
            chk("spur_pend", int'(o_pending_count), 3 - k);
            chk("spur_no_pulse", int'(o_dma_complete), 0);
            compare_model();
            tick();
        end
        chk("spur_flag_set", int'(o_spurious), 1);
        apply(0, 0, 1, 0, 0, 1); compare_model(); tick();
        chk("spur_flag_clear", int'(o_spurious), 0);

        // Overflow: two max doorbells with the stream stalled
        do_reset();
        apply(1, 12'h004, 0, 1, 15, 0); compare_model(); tick();
        apply(1, 12'h004, 0, 1, 15, 0); compare_model(); tick();
        chk("ovf_pend_clamp", int'(o_pending_count), PMAX);
        chk("ovf_flag", int'(o_overflow), 1);
        compare_model();

        // Reset asserted while the pulse is out
        do_reset();
        apply(1, 12'h000, 1, 0, 0, 0); compare_model(); tick();
        apply(0, 12'h000, 1, 1, 1, 0); compare_model(); tick();
        apply(0, 12'h000, 1, 0, 0, 0); compare_model(); tick();
        apply(1, 12'h000, 1, 0, 0, 0);
        chk("rst_pulse_before", int'(o_dma_complete), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_pulse_drop", int'(o_dma_complete), 0);
        chk("rst_pend", int'(o_pending_count), 0);
        chk("rst_open", int'(o_open_count), 0);
        chk("rst_mvalid", int'(m_addr_valid), 0);
        chk("rst_sready", int'(s_addr_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(1, 12'h000, 1, 0, 0, 0); compare_model(); tick();
        chk("rst_first_wrap_open", int'(o_open_count), 1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 4) == 0) ? 12'h000 : 12'($urandom_range(1, 4095)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0,
                  ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                  $urandom_range(0, 31) == 0);
            compare_model();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
